// File: rtl/wb_pkg.sv
// Shared types and helpers for the weight-buffer loader: FSM states, default
// geometry and the channel/tap to bit-offset mapping of a kernel word.
package wb_pkg;

  localparam int M_DEF  = 8;
  localparam int K_DEF  = 9;
  localparam int C_DEF  = 2;
  localparam int WORD_W = M_DEF * C_DEF * K_DEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_ACT,
    ST_PREF,
    ST_RUN
  } state_t;

  // LSB offset of (ch, tap); ch0 tap0 sits in the MSBs of the word.
  function automatic int tap_offset(input int m, input int c, input int k,
                                    input int ch, input int tap);
    return (c * k - 1 - (ch * k + tap)) * m;
  endfunction

endpackage

// File: rtl/wb_bank.sv
// Active/shadow weight bank. The active word can be loaded straight from the
// ROM or from the shadow word; the shadow word loads only from the ROM.
module wb_bank #(
  parameter int W = 144
) (
  input  logic         clk,
  input  logic         Rst_n,
  input  logic         load_act,
  input  logic         load_sh,
  input  logic         swap,
  input  logic [W-1:0] din,
  output logic [W-1:0] act
);

  logic [W-1:0] sh;

  // NOTE: these wide registers do take the reset so the MAC array sees zero
  // weights out of reset; a plain storage array would normally be left unreset.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      act <= '0;
      sh  <= '0;
    end else begin
      if (load_act)  act <= din;
      else if (swap) act <= sh;
      if (load_sh)   sh  <= din;
    end
  end

endmodule

// File: rtl/wb_dbuf_loader.sv
// Double-buffered weight loader: streams one ROM word per filter, prefetching
// the next filter into the shadow bank so swaps on fmap_finish cost no cycles.
module wb_dbuf_loader
  import wb_pkg::*;
#(
  parameter int M       = M_DEF,
  parameter int K       = K_DEF,
  parameter int C       = C_DEF,
  parameter int NF      = 8,
  parameter int ROM_LAT = 1,
  parameter int AW      = 8
) (
  input  logic                clk,
  input  logic                Rst_n,
  input  logic                start,
  input  logic                fmap_finish,
  output logic [AW-1:0]       rom_addr,
  input  logic [M*C*K-1:0]    rom_rd_data,
  output logic [M*C*K-1:0]    weights,
  output logic                w_valid,
  output logic [AW-1:0]       filter_count,
  output logic                filter_finish,
  output logic                busy
);

  localparam int              WW     = M * C * K;
  localparam int              CW     = $clog2(ROM_LAT + 1);
  localparam logic [CW-1:0]   LAT_C  = CW'(ROM_LAT);
  localparam logic [AW-1:0]   LAST_F = AW'(NF - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          shadow_full;
  logic          pending;

  logic capture, last, need_pref;
  logic load_act, load_sh, swap, advance;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    capture   = (cnt == LAT_C);
    last      = (filter_count == LAST_F);
    need_pref = (int'(filter_count) + 2) < NF;
    load_act  = 1'b0;
    load_sh   = 1'b0;
    swap      = 1'b0;
    case (state)
      ST_LOAD_ACT: load_act = capture;
      ST_PREF: begin
        // A finish already waiting (or arriving now) takes the fresh ROM word
        // straight into the active bank instead of parking it in the shadow.
        if (capture) begin
          if (pending || fmap_finish) load_act = 1'b1;
          else                        load_sh  = 1'b1;
        end
      end
      ST_RUN:  swap = fmap_finish && !last && shadow_full;
      default: ;
    endcase
    advance = ((state == ST_PREF) && load_act) || swap;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments below deliberately override
  // the per-state ones when a filter advance happens.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      shadow_full   <= 1'b0;
      pending       <= 1'b0;
      rom_addr      <= '0;
      filter_count  <= '0;
      w_valid       <= 1'b0;
      filter_finish <= 1'b0;
      busy          <= 1'b0;
    end else begin
      filter_finish <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rom_addr    <= '0;
            cnt         <= '0;
            shadow_full <= 1'b0;
            pending     <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_LOAD_ACT;
          end
        end
        ST_LOAD_ACT: begin
          if (capture) begin
            filter_count <= '0;
            w_valid      <= 1'b1;
            if (NF > 1) begin
              rom_addr <= AW'(1);
              cnt      <= '0;
              state    <= ST_PREF;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PREF: begin
          if (capture) begin
            if (load_sh) begin
              shadow_full <= 1'b1;
              state       <= ST_RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (fmap_finish) begin
              pending <= 1'b1;
              w_valid <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (fmap_finish && last) begin
            filter_finish <= 1'b1;
            w_valid       <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (advance) begin
        filter_count <= filter_count + 1'b1;
        shadow_full  <= 1'b0;
        pending      <= 1'b0;
        w_valid      <= 1'b1;
        if (need_pref) begin
          rom_addr <= filter_count + AW'(2);
          cnt      <= '0;
          state    <= ST_PREF;
        end else begin
          state <= ST_RUN;
        end
      end
    end
  end

  wb_bank #(.W(WW)) u_bank (
    .clk      (clk),
    .Rst_n    (Rst_n),
    .load_act (load_act),
    .load_sh  (load_sh),
    .swap     (swap),
    .din      (rom_rd_data),
    .act      (weights)
  );

endmodule

// File: tb/tb_wb_dbuf_loader.sv
// Directed bench: three loader instances (NF=4/LAT=1, NF=4/LAT=3, NF=1/LAT=1)
// each fed by a ROM model whose word f has every byte equal to f+1.
module tb_wb_dbuf_loader;
  import wb_pkg::*;

  localparam int AW = 8;

  logic clk, Rst_n;
  int   n_cmp, n_bad, drops_a;
  logic watch_a;

  logic              start_a, fin_a, wv_a, ff_a, busy_a;
  logic [AW-1:0]     addr_a, fc_a;
  logic [WORD_W-1:0] rd_a, w_a;
  logic              start_b, fin_b, wv_b, ff_b, busy_b;
  logic [AW-1:0]     addr_b, fc_b;
  logic [WORD_W-1:0] rd_b, w_b;
  logic [WORD_W-1:0] pipe_b [3];
  logic              start_c, fin_c, wv_c, ff_c, busy_c;
  logic [AW-1:0]     addr_c, fc_c;
  logic [WORD_W-1:0] rd_c, w_c;

  wb_dbuf_loader #(.NF(4), .ROM_LAT(1)) u_a (
    .clk(clk), .Rst_n(Rst_n), .start(start_a), .fmap_finish(fin_a),
    .rom_addr(addr_a), .rom_rd_data(rd_a), .weights(w_a), .w_valid(wv_a),
    .filter_count(fc_a), .filter_finish(ff_a), .busy(busy_a));

  wb_dbuf_loader #(.NF(4), .ROM_LAT(3)) u_b (
    .clk(clk), .Rst_n(Rst_n), .start(start_b), .fmap_finish(fin_b),
    .rom_addr(addr_b), .rom_rd_data(rd_b), .weights(w_b), .w_valid(wv_b),
    .filter_count(fc_b), .filter_finish(ff_b), .busy(busy_b));

  wb_dbuf_loader #(.NF(1), .ROM_LAT(1)) u_c (
    .clk(clk), .Rst_n(Rst_n), .start(start_c), .fmap_finish(fin_c),
    .rom_addr(addr_c), .rom_rd_data(rd_c), .weights(w_c), .w_valid(wv_c),
    .filter_count(fc_c), .filter_finish(ff_c), .busy(busy_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WORD_W-1:0] fill(input logic [7:0] b);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int ch = 0; ch < C_DEF; ch++)
      for (int tap = 0; tap < K_DEF; tap++)
        w[tap_offset(M_DEF, C_DEF, K_DEF, ch, tap) +: 8] = b;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] rom_word(input logic [AW-1:0] a);
    return fill(a + 8'd1);
  endfunction

  // Synchronous ROM models: latency 1 for A and C, latency 3 for B.
  always @(posedge clk) begin
    rd_a      <= rom_word(addr_a);
    rd_c      <= rom_word(addr_c);
    pipe_b[0] <= rom_word(addr_b);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rd_b = pipe_b[2];

  always @(negedge clk) if (watch_a && !wv_a) drops_a++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk(input string tag,
                     input logic [WORD_W-1:0] w, input logic [AW-1:0] fc,
                     input logic wv, input logic bsy, input logic ff,
                     input logic [AW-1:0] addr,
                     input logic [7:0] e_b, input logic [AW-1:0] e_fc,
                     input logic e_wv, input logic e_bsy, input logic e_ff,
                     input logic [AW-1:0] e_addr);
    check({tag, ".weights"},       w,              fill(e_b));
    check({tag, ".filter_count"},  WORD_W'(fc),    WORD_W'(e_fc));
    check({tag, ".w_valid"},       WORD_W'(wv),    WORD_W'(e_wv));
    check({tag, ".busy"},          WORD_W'(bsy),   WORD_W'(e_bsy));
    check({tag, ".filter_finish"}, WORD_W'(ff),    WORD_W'(e_ff));
    check({tag, ".rom_addr"},      WORD_W'(addr),  WORD_W'(e_addr));
  endtask

  task automatic chk_a(input string t, input logic [7:0] b, input logic [AW-1:0] fc,
                       input logic wv, input logic bsy, input logic ff, input logic [AW-1:0] ad);
    chk(t, w_a, fc_a, wv_a, busy_a, ff_a, addr_a, b, fc, wv, bsy, ff, ad);
  endtask
  task automatic chk_b(input string t, input logic [7:0] b, input logic [AW-1:0] fc,
                       input logic wv, input logic bsy, input logic ff, input logic [AW-1:0] ad);
    chk(t, w_b, fc_b, wv_b, busy_b, ff_b, addr_b, b, fc, wv, bsy, ff, ad);
  endtask
  task automatic chk_c(input string t, input logic [7:0] b, input logic [AW-1:0] fc,
                       input logic wv, input logic bsy, input logic ff, input logic [AW-1:0] ad);
    chk(t, w_c, fc_c, wv_c, busy_c, ff_c, addr_c, b, fc, wv, bsy, ff, ad);
  endtask

  // One vector: inputs held for the first edge, then n edges in total before
  // the outputs are compared.
  typedef struct {
    logic          st;
    logic          fin;
    int            n;
    logic [7:0]    b;
    logic [AW-1:0] fc;
    logic          wv;
    logic          bsy;
    logic          ff;
    logic [AW-1:0] addr;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic fin, input int n,
                              input logic [7:0] b, input logic [AW-1:0] fc,
                              input logic wv, input logic bsy, input logic ff,
                              input logic [AW-1:0] addr);
    vec_t v;
    v.st = st; v.fin = fin; v.n = n; v.b = b; v.fc = fc;
    v.wv = wv; v.bsy = bsy; v.ff = ff; v.addr = addr;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    n_cmp = 0; n_bad = 0; drops_a = 0; watch_a = 1'b0;
    Rst_n = 1'b0;
    start_a = 0; fin_a = 0; start_b = 0; fin_b = 0; start_c = 0; fin_c = 0;

    //             st fin  n  byte fc wv bsy ff addr
    tbl.push_back(mk(1, 0, 1, 8'h00, 0, 0, 1, 0, 0));  // start accepted
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 0));  // waiting on ROM
    tbl.push_back(mk(0, 0, 1, 8'h01, 0, 1, 1, 0, 1));  // filter 0 live, prefetch 1
    tbl.push_back(mk(0, 0, 2, 8'h01, 0, 1, 1, 0, 1));  // shadow loaded
    tbl.push_back(mk(0, 1, 1, 8'h02, 1, 1, 1, 0, 2));  // swap to 1
    tbl.push_back(mk(0, 0, 9, 8'h02, 1, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 1, 8'h03, 2, 1, 1, 0, 3));  // swap to 2
    tbl.push_back(mk(0, 0, 9, 8'h03, 2, 1, 1, 0, 3));
    tbl.push_back(mk(0, 1, 1, 8'h04, 3, 1, 1, 0, 3));  // swap to 3, no prefetch
    tbl.push_back(mk(0, 0, 9, 8'h04, 3, 1, 1, 0, 3));
    tbl.push_back(mk(0, 1, 1, 8'h04, 3, 0, 0, 1, 3));  // last filter done
    tbl.push_back(mk(0, 0, 1, 8'h04, 3, 0, 0, 0, 3));  // pulse is one cycle
    tbl.push_back(mk(0, 1, 1, 8'h04, 3, 0, 0, 0, 3));  // finish in IDLE ignored
    tbl.push_back(mk(1, 1, 1, 8'h04, 3, 0, 1, 0, 0));  // start wins over finish
    tbl.push_back(mk(0, 0, 3, 8'h01, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 1, 8'h01, 0, 1, 1, 0, 1));  // start while busy ignored
    tbl.push_back(mk(0, 0, 5, 8'h01, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 1, 8'h01, 0, 1, 1, 0, 1));  // start in RUN ignored

    #22;
    chk_a("a_reset", 8'h00, 0, 0, 0, 0, 0);
    chk_b("b_reset", 8'h00, 0, 0, 0, 0, 0);
    Rst_n = 1'b1;
    step();

    // NF=1: no prefetch, finish straight away.
    start_c = 1; step(); start_c = 0;
    chk_c("c_start", 8'h00, 0, 0, 1, 0, 0);
    step(); step();
    chk_c("c_load", 8'h01, 0, 1, 1, 0, 0);
    step(); step();
    chk_c("c_nopref", 8'h01, 0, 1, 1, 0, 0);
    fin_c = 1; step(); fin_c = 0;
    chk_c("c_fin", 8'h01, 0, 0, 0, 1, 0);
    step();
    chk_c("c_idle", 8'h01, 0, 0, 0, 0, 0);

    // ROM_LAT=3: stall on early finish, then a finish coinciding with capture.
    start_b = 1; step(); start_b = 0;
    step(); step(); step();
    chk_b("b_wait", 8'h00, 0, 0, 1, 0, 0);
    step();
    chk_b("b_load", 8'h01, 0, 1, 1, 0, 1);
    fin_b = 1; step();
    chk_b("b_stall", 8'h01, 0, 0, 1, 0, 1);
    step(); fin_b = 0;
    chk_b("b_stall2", 8'h01, 0, 0, 1, 0, 1);
    step(); step();
    chk_b("b_land", 8'h02, 1, 1, 1, 0, 2);
    fin_b = 1; step(); fin_b = 0;
    chk_b("b_stall3", 8'h02, 1, 0, 1, 0, 2);
    fin_b = 1; step(); fin_b = 0;
    step(); step();
    chk_b("b_land2", 8'h03, 2, 1, 1, 0, 3);
    step(); step(); step();
    chk_b("b_pre_simul", 8'h03, 2, 1, 1, 0, 3);
    fin_b = 1; step(); fin_b = 0;
    chk_b("b_simul", 8'h04, 3, 1, 1, 0, 3);
    fin_b = 1; step(); fin_b = 0;
    chk_b("b_fin", 8'h04, 3, 0, 0, 1, 3);
    step();
    chk_b("b_idle", 8'h04, 3, 0, 0, 0, 3);

    // NF=4, ROM_LAT=1 table.
    for (int i = 0; i < tbl.size(); i++) begin
      start_a = tbl[i].st;
      fin_a   = tbl[i].fin;
      step();
      start_a = 0;
      fin_a   = 0;
      for (int j = 1; j < tbl[i].n; j++) step();
      chk_a($sformatf("a_v%0d", i), tbl[i].b, tbl[i].fc, tbl[i].wv,
            tbl[i].bsy, tbl[i].ff, tbl[i].addr);
      if (i == 2)  watch_a = 1'b1;
      if (i == 9)  watch_a = 1'b0;
    end
    check("a_no_bubble", WORD_W'(drops_a), WORD_W'(0));

    // Reset while prefetching filter 2, then a clean restart.
    fin_a = 1; step(); fin_a = 0;
    chk_a("a_pref2", 8'h02, 1, 1, 1, 0, 2);
    #3 Rst_n = 1'b0;
    #1 chk_a("a_rst_async", 8'h00, 0, 0, 0, 0, 0);
    step();
    chk_a("a_rst_hold", 8'h00, 0, 0, 0, 0, 0);
    Rst_n = 1'b1;
    start_a = 1; step(); start_a = 0;
    step(); step();
    chk_a("a_restart", 8'h01, 0, 1, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
